// File: rtl/dac_readback_if.sv
// Request/result handshake and shared SPI lines of the AD5791 read-back engine.
// The slave modport is the engine's view. The master modport is the
// environment's view: flow_ctrl, the bus arbiter and the DAC SDO line.
interface dac_readback_if;
  logic        rd_req;
  logic [2:0]  rd_addr;
  logic        rd_busy;
  logic        rd_dv;
  logic [19:0] rd_data;
  logic        rd_err;
  logic        bus_req;
  logic        bus_gnt;
  logic        sclk;
  logic        sdo;
  logic        sdin;
  logic        sync;

  modport master (
    output rd_req, rd_addr, bus_gnt, sdin,
    input  rd_busy, rd_dv, rd_data, rd_err, bus_req, sclk, sdo, sync
  );

  modport slave (
    input  rd_req, rd_addr, bus_gnt, sdin,
    output rd_busy, rd_dv, rd_data, rd_err, bus_req, sclk, sdo, sync
  );
endinterface

// File: rtl/dac_readback.sv
// AD5791 register read-back engine (receive direction of the DAC serial link).
// A read is two frames. Frame 1 carries R/W=1 plus the register address.
// Frame 2 is a NOP; while it shifts out, the DAC returns the register on SDO.
// The SPI lines are shared with the write path, so the engine requests the
// bus and waits for the grant before it drives any SCLK or SYNC activity.
module dac_readback #(
  parameter int CLK_DIV  = 4,  // mclk cycles per SCLK half-period
  parameter int SYNC_GAP = 2   // mclk cycles with sync low between the frames
) (
  input  logic           mclk,
  input  logic           rst_n,
  dac_readback_if.slave  rb
);

  localparam int PH_W  = $clog2(2 * CLK_DIV);
  localparam int GAP_W = (SYNC_GAP > 1) ? $clog2(SYNC_GAP) : 1;

  localparam logic [PH_W-1:0]  PH_FALL  = PH_W'(CLK_DIV - 1);      // last sclk-high cycle
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * CLK_DIV - 1);  // last cycle of a bit
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SYNC_GAP - 1);
  localparam logic [4:0]       BIT_LAST = 5'd23;
  localparam logic [23:0]      NOP_WORD = 24'h000000;

  typedef enum logic [2:0] {IDLE, REQ, F1, GAP, F2, DONE} state_t;

  state_t            state;
  logic [PH_W-1:0]   ph;        // position inside the current bit
  logic [4:0]        bit_cnt;   // bit index inside the current frame
  logic [GAP_W-1:0]  gap_cnt;
  logic [23:0]       tx_sr;     // outgoing frame, MSB first
  logic [23:0]       cap;       // incoming DAC SDO word, MSB first

  logic              rd_busy_q;
  logic              rd_dv_q;
  logic [19:0]       rd_data_q;
  logic              rd_err_q;
  logic              bus_req_q;
  logic              sclk_q;
  logic              sdo_q;
  logic              sync_q;

  // Only registers 1..3 are readable; everything else is answered locally.
  function automatic logic addr_legal(input logic [2:0] a);
    return (a[2] == 1'b0) && (a[1:0] != 2'b00);
  endfunction

  logic in_frame;
  logic ph_end;
  logic ph_fall;
  logic last_bit;
  logic accept_ok;
  logic f1_start;
  logic f2_start;
  logic next_bit;
  logic f1_end;

  assign in_frame  = (state == F1) || (state == F2);
  assign ph_end    = (ph == PH_LAST);
  assign ph_fall   = (ph == PH_FALL);
  assign last_bit  = (bit_cnt == BIT_LAST);
  assign accept_ok = (state == IDLE) && rb.rd_req && addr_legal(rb.rd_addr);
  assign f1_start  = (state == REQ) && rb.bus_gnt;
  assign f2_start  = (state == GAP) && (gap_cnt == GAP_LAST);
  assign next_bit  = in_frame && ph_end && !last_bit;
  assign f1_end    = (state == F1) && ph_end && last_bit;

  // Transaction sequencing; every bus and result output is registered here.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ph        <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      rd_busy_q <= 1'b0;
      rd_dv_q   <= 1'b0;
      rd_data_q <= '0;
      rd_err_q  <= 1'b0;
      bus_req_q <= 1'b0;
      sclk_q    <= 1'b0;
      sdo_q     <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      rd_dv_q <= 1'b0;
      case (state)
        IDLE: begin
          if (rb.rd_req) begin
            rd_busy_q <= 1'b1;
            if (addr_legal(rb.rd_addr)) begin
              state     <= REQ;
              bus_req_q <= 1'b1;
            end else begin
              // Illegal address: report at once, never touch the bus.
              state    <= DONE;
              rd_dv_q  <= 1'b1;
              rd_err_q <= 1'b1;
            end
          end
        end
        REQ: begin
          if (rb.bus_gnt) begin
            state   <= F1;
            sync_q  <= 1'b1;
            sclk_q  <= 1'b1;
            sdo_q   <= tx_sr[23];
            ph      <= '0;
            bit_cnt <= '0;
          end
        end
        F1, F2: begin
          if (ph_end) begin
            if (last_bit) begin
              sclk_q <= 1'b0;
              sdo_q  <= 1'b0;
              sync_q <= 1'b0;
              if (state == F1) begin
                state   <= GAP;
                gap_cnt <= '0;
              end else begin
                state     <= DONE;
                rd_dv_q   <= 1'b1;
                rd_err_q  <= 1'b0;
                rd_data_q <= cap[19:0];
                bus_req_q <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              ph      <= '0;
              sclk_q  <= 1'b1;
              sdo_q   <= tx_sr[23];
            end
          end else begin
            ph <= ph + 1'b1;
            if (ph_fall) sclk_q <= 1'b0;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state   <= F2;
            sync_q  <= 1'b1;
            sclk_q  <= 1'b1;
            sdo_q   <= tx_sr[23];
            ph      <= '0;
            bit_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          rd_busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Frame shift registers: load the read command, swap in the NOP between
  // frames, and sample SDO in the cycle where sclk drops (DAC output is stable).
  always_ff @(posedge mclk) begin
    if (accept_ok) begin
      tx_sr <= {1'b1, rb.rd_addr, 20'h00000};
    end else if (f1_end) begin
      tx_sr <= NOP_WORD;
    end else if (f1_start || f2_start || next_bit) begin
      tx_sr <= {tx_sr[22:0], 1'b0};
    end
    if ((state == F2) && ph_fall) begin
      cap <= {cap[22:0], rb.sdin};
    end
  end

  assign rb.rd_busy = rd_busy_q;
  assign rb.rd_dv   = rd_dv_q;
  assign rb.rd_data = rd_data_q;
  assign rb.rd_err  = rd_err_q;
  assign rb.bus_req = bus_req_q;
  assign rb.sclk    = sclk_q;
  assign rb.sdo     = sdo_q;
  assign rb.sync    = sync_q;

endmodule

// File: tb/tb_dac_readback.sv
// Bench for dac_readback: a driver issues reads, a behavioural DAC answers on
// SDO, an arbiter grants the bus after a chosen delay, and a monitor pops the
// expected results from a scoreboard queue whenever rd_dv is seen.
module tb_dac_readback;
  localparam int CLK_DIV  = 4;
  localparam int SYNC_GAP = 2;
  // Two 24-bit frames of 2*CLK_DIV cycles, the gap, plus REQ and DONE.
  localparam int LAT      = 2 + 2 * 48 * CLK_DIV + SYNC_GAP;
  localparam int TIMEOUT  = 3000;

  logic mclk = 1'b0;
  logic rst_n;

  dac_readback_if rb();

  dac_readback #(.CLK_DIV(CLK_DIV), .SYNC_GAP(SYNC_GAP)) dut (
    .mclk  (mclk),
    .rst_n (rst_n),
    .rb    (rb)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    logic        err;
    logic [19:0] data;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          gnt_delay = 0;
  int          viol = 0;
  int          dv_seen = 0;
  int          dv_expected = 0;
  logic [2:0]  cur_addr = 3'd0;
  logic [19:0] cur_val = 20'h0;
  logic [19:0] model_data = 20'h0;

  always @(posedge mclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Arbiter: grant constantly when the delay is 0, else gnt_delay cycles after bus_req.
  int arb_cnt = 0;
  always @(posedge mclk) begin
    #1;
    if (gnt_delay == 0) begin
      rb.bus_gnt = 1'b1;
    end else if (!rb.bus_req) begin
      arb_cnt    = 0;
      rb.bus_gnt = 1'b0;
    end else begin
      arb_cnt++;
      if (arb_cnt > gnt_delay) rb.bus_gnt = 1'b1;
    end
  end

  // Behavioural DAC: collects each 24-bit frame on sclk falls; after a read
  // command it returns {0, addr, register} during the next frame.
  logic [23:0] rx = '0;
  int          nb = 0;
  logic [23:0] out_sr = '0;
  bit          dac_ph = 1'b0;
  logic        sclk_d = 1'b0;
  logic        sync_d = 1'b0;
  always @(negedge mclk) begin
    if (sclk_d && !rb.sclk && rb.sync) begin
      rx = {rx[22:0], rb.sdo};
      nb++;
    end
    if (sync_d && !rb.sync) begin
      if (nb == 24) begin
        if (!dac_ph) begin
          check("frame1_sdo", 32'(rx), 32'({1'b1, cur_addr, 20'h00000}));
          out_sr = {1'b0, cur_addr, cur_val};
          dac_ph = 1'b1;
        end else begin
          check("frame2_sdo", 32'(rx), 32'h0);
          out_sr = '0;
          dac_ph = 1'b0;
        end
      end else begin
        out_sr = '0;
        dac_ph = 1'b0;
      end
      nb = 0;
    end
    if (!sclk_d && rb.sclk && rb.sync) begin
      rb.sdin = out_sr[23];
      out_sr  = {out_sr[22:0], 1'b0};
    end
    sclk_d = rb.sclk;
    sync_d = rb.sync;
    if ((rb.sclk === 1'b1 || rb.sync === 1'b1) && rb.bus_gnt !== 1'b1) viol++;
  end

  // Scoreboard monitor.
  bit prev_dv = 1'b0;
  always @(negedge mclk) begin
    if (rst_n === 1'b1) begin
      if (prev_dv) check("rd_busy_after_dv", 32'(rb.rd_busy), 32'h0);
      if (rb.rd_dv === 1'b1) begin
        dv_seen++;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rd_dv: got rd_dv=1, expected no result (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("rd_data", 32'(rb.rd_data), 32'(e.data));
          check("rd_err", 32'(rb.rd_err), 32'(e.err));
          check("rd_dv_cycle", 32'(cyc), 32'(e.cyc));
          check("rd_busy_at_dv", 32'(rb.rd_busy), 32'h1);
        end
      end
      prev_dv = (rb.rd_dv === 1'b1);
    end else begin
      prev_dv = 1'b0;
    end
  end

  // Issue one read in the next cycle; exp=0 means it will be aborted by reset.
  task automatic issue(input logic [2:0] a, input logic [19:0] v, input int dly, input bit exp);
    bit legal;
    int t0;
    legal     = (a == 3'd1) || (a == 3'd2) || (a == 3'd3);
    gnt_delay = dly;
    @(posedge mclk);
    #1;
    cur_addr   = a;
    cur_val    = v;
    rb.rd_addr = a;
    rb.rd_req  = 1'b1;
    t0         = cyc;
    if (exp) begin
      dv_expected++;
      if (legal) begin
        model_data = v;
        sbq.push_back('{err: 1'b0, data: v, cyc: t0 + LAT + dly});
      end else begin
        sbq.push_back('{err: 1'b1, data: model_data, cyc: t0 + 1});
      end
    end
    @(posedge mclk);
    #1;
    rb.rd_req = 1'b0;
    check("rd_busy_after_accept", 32'(rb.rd_busy), 32'h1);
    check("bus_req_after_accept", 32'(rb.bus_req), 32'(legal));
    if (!legal) begin
      logic act;
      act = 1'b0;
      repeat (3) begin
        act = act | rb.sclk | rb.sync | rb.bus_req;
        @(posedge mclk);
        #1;
      end
      check("err_path_bus_idle", 32'(act), 32'h0);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sbq.size() != 0 || rb.rd_busy !== 1'b0) && n < TIMEOUT) begin
      @(posedge mclk);
      #1;
      n++;
    end
    if (n >= TIMEOUT) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got %0d pending results, expected 0", sbq.size());
    end
  endtask

  initial begin
    logic quiet;
    rst_n      = 1'b0;
    rb.rd_req  = 1'b0;
    rb.rd_addr = 3'd0;

    // Reset state.
    repeat (3) @(posedge mclk);
    #1;
    check("rst_rd_busy", 32'(rb.rd_busy), 32'h0);
    check("rst_rd_dv",   32'(rb.rd_dv),   32'h0);
    check("rst_rd_data", 32'(rb.rd_data), 32'h0);
    check("rst_rd_err",  32'(rb.rd_err),  32'h0);
    check("rst_bus_req", 32'(rb.bus_req), 32'h0);
    check("rst_sclk",    32'(rb.sclk),    32'h0);
    check("rst_sdo",     32'(rb.sdo),     32'h0);
    check("rst_sync",    32'(rb.sync),    32'h0);
    rst_n = 1'b1;
    quiet = 1'b0;
    repeat (20) begin
      @(posedge mclk);
      #1;
      quiet = quiet | rb.rd_busy | rb.rd_dv | rb.bus_req | rb.sclk | rb.sync | rb.sdo;
    end
    check("quiet_after_reset", 32'(quiet), 32'h0);

    // Register 2 with the grant already present, then with a 10-cycle grant wait.
    issue(3'd2, 20'h00312, 0, 1'b1);
    wait_idle();
    issue(3'd2, 20'h00312, 10, 1'b1);
    wait_idle();

    // Illegal address: immediate error, previous data kept.
    issue(3'd4, 20'h5A5A5, 0, 1'b1);
    wait_idle();

    // Reset at the start of bit 10 of frame 2; the read must vanish.
    issue(3'd1, 20'h12345, 0, 1'b0);
    repeat (196 + 10 * 2 * CLK_DIV - 1) @(posedge mclk);
    #1;
    check("frame2_sync_before_rst", 32'(rb.sync), 32'h1);
    check("frame2_sclk_before_rst", 32'(rb.sclk), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_sync",    32'(rb.sync),    32'h0);
    check("abort_sclk",    32'(rb.sclk),    32'h0);
    check("abort_sdo",     32'(rb.sdo),     32'h0);
    check("abort_bus_req", 32'(rb.bus_req), 32'h0);
    check("abort_rd_busy", 32'(rb.rd_busy), 32'h0);
    check("abort_rd_err",  32'(rb.rd_err),  32'h0);
    model_data = 20'h0;
    repeat (2) @(posedge mclk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge mclk);
    issue(3'd1, 20'($urandom()), 0, 1'b1);
    wait_idle();

    // rd_req held (illegal addr) through busy and the rd_dv cycle is ignored;
    // a request in the cycle after rd_dv is accepted.
    issue(3'd3, 20'($urandom()), 0, 1'b1);
    repeat (5) @(posedge mclk);
    #1;
    rb.rd_addr = 3'd4;
    rb.rd_req  = 1'b1;
    begin
      int n;
      n = 0;
      while (rb.rd_dv !== 1'b1 && n < TIMEOUT) begin
        @(posedge mclk);
        #1;
        n++;
      end
      if (n >= TIMEOUT) begin
        checks++;
        errors++;
        $display("FAIL busy_rd_dv_timeout: got no rd_dv, expected one");
      end
    end
    issue(3'd3, 20'($urandom()), 0, 1'b1);
    wait_idle();

    // Randomised reads: any address, random contents, random grant delay.
    for (int i = 0; i < 12; i++) begin
      issue(3'($urandom_range(0, 7)), 20'($urandom()), int'($urandom_range(0, 5)), 1'b1);
      wait_idle();
    end

    repeat (3) @(posedge mclk);
    #1;
    check("no_spi_without_grant", 32'(viol), 32'h0);
    check("rd_dv_count", 32'(dv_seen), 32'(dv_expected));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
